// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command/response sequencer around a combinational 8-bit ALU
// Launches operands, waits SETTLE_CYCLES edges, captures the result with flags and an accumulator.
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] cmd_sel,
  input  logic       cmd_use_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_dz,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SEL_ADD   = 4'b0000;
  localparam logic [3:0] SEL_DIV   = 4'b0011;
  localparam logic [3:0] CNT_LAST  = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] acc_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [3:0] alu_sel_q;
  logic [7:0] rsp_result_q;
  logic       rsp_carry_q;
  logic       rsp_zero_q;
  logic       rsp_dz_q;
  logic       rsp_valid_q;
  logic       busy_q;

  logic       accept;
  logic       dz_d;
  logic [7:0] result_d;
  logic       carry_d;
  logic [7:0] launch_a_d;

  // In RESP the ready is passed through so a new command can ride the consume edge.
  always_comb begin
    cmd_ready  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    accept     = cmd_valid && cmd_ready;
    launch_a_d = cmd_use_acc ? acc_q : cmd_a;
  end

  // ALU carry always reflects A+B, so it is only meaningful for the add opcode.
  always_comb begin
    dz_d     = (alu_sel_q == SEL_DIV) && (alu_b_q == 8'h00);
    result_d = dz_d ? 8'hFF : alu_out;
    carry_d  = (alu_sel_q == SEL_ADD) ? alu_carry : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      acc_q        <= 8'h00;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_sel_q    <= 4'h0;
      rsp_result_q <= 8'h00;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_dz_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q     <= launch_a_d;
            alu_b_q     <= cmd_b;
            alu_sel_q   <= cmd_sel;
            cnt_q       <= 4'd0;
            state_q     <= DRIVE;
            busy_q      <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            rsp_result_q <= result_d;
            rsp_carry_q  <= carry_d;
            rsp_zero_q   <= (result_d == 8'h00);
            rsp_dz_q     <= dz_d;
            acc_q        <= result_d;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (cmd_valid) begin
              alu_a_q   <= launch_a_d;
              alu_b_q   <= cmd_b;
              alu_sel_q <= cmd_sel;
              cnt_q     <= 4'd0;
              state_q   <= DRIVE;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_dz     = rsp_dz_q;
  assign busy       = busy_q;

endmodule
